scs8hd_a32oi_pipe: RTL

SCS8HD_A32OI_PIPE -- requirements
Module: scs8hd_a32oi_pipe

---
 rtl/scs8hd_a32oi_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/scs8hd_a32oi_pipe.sv
// Pipelined bank of WIDTH independent a32oi lanes with a valid/ready
// handshake, DEPTH register stages that collapse bubbles, and a flush input.
module scs8hd_a32oi_pipe #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 2,
    parameter int INVERT = 1
) (
`ifdef SC_USE_PG_PIN
    input  logic                           vpwr,
    input  logic                           vgnd,
    input  logic                           vpb,
    input  logic                           vnb,
`endif
    input  logic                           CLK,
    input  logic                           RESETB,
    input  logic                           FLUSH,
    input  logic [WIDTH-1:0]               A1,
    input  logic [WIDTH-1:0]               A2,
    input  logic [WIDTH-1:0]               A3,
    input  logic [WIDTH-1:0]               B1,
    input  logic [WIDTH-1:0]               B2,
    input  logic                           VALID_IN,
    output logic                           READY_OUT,
    output logic [WIDTH-1:0]               Y,
    output logic                           VALID_OUT,
    input  logic                           READY_IN,
    output logic [$clog2(DEPTH+1)-1:0]     OCCUPANCY
);

    localparam int OW = $clog2(DEPTH + 1);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply0 vgnd;
    supply1 vpb;
    supply0 vnb;
`endif

    logic [WIDTH-1:0] data_q     [DEPTH];
    logic [WIDTH-1:0] data_d     [DEPTH];
    logic [WIDTH-1:0] up_data_s  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] up_valid_s;
    logic [DEPTH-1:0] adv_s;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;
    logic [WIDTH-1:0] lane_s;
    logic             pwr_ok_s;
    logic             ready_s;
    logic             xfer_in_s;

    function automatic logic [OW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OW-1:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n = n + OW'(v[k]);
        end
        return n;
    endfunction

    assign pwr_ok_s = vpwr & ~vgnd & vpb & ~vnb;

    if (INVERT != 0) begin : g_inv
        assign lane_s = ~((A1 & A2 & A3) | (B1 & B2));
    end else begin : g_noinv
        assign lane_s = (A1 & A2 & A3) | (B1 & B2);
    end

    // Advance chain: a stage moves when it is empty or the stage below it moves.
    always_comb begin
        adv_s = '0;
        adv_s[DEPTH-1] = ~valid_q[DEPTH-1] | READY_IN;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv_s[k] = ~valid_q[k] | adv_s[k+1];
        end
    end

    assign ready_s   = adv_s[0] & ~FLUSH & pwr_ok_s;
    assign xfer_in_s = VALID_IN & ready_s;
    // Flops are held in reset anyway, so RESETB only needs to mask the port.
    assign READY_OUT = ready_s & RESETB;

    // Upstream view of each stage: stage 0 sees the lane function, others the previous stage.
    always_comb begin
        up_valid_s    = '0;
        up_valid_s[0] = xfer_in_s;
        up_data_s[0]  = lane_s;
        for (int k = 1; k < DEPTH; k++) begin
            up_valid_s[k] = valid_q[k-1];
            up_data_s[k]  = data_q[k-1];
        end
    end

    // Next-state for valid bits, data registers and occupancy.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (FLUSH) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv_s[k]) begin
                    valid_d[k] = up_valid_s[k];
                    if (up_valid_s[k]) begin
                        data_d[k] = up_data_s[k];
                    end else begin
                        data_d[k] = data_q[k];
                    end
                end else begin
                    valid_d[k] = valid_q[k];
                    data_d[k]  = data_q[k];
                end
            end
        end
        occ_d = popcount(valid_d);
    end

    // Pipeline state registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign Y         = data_q[DEPTH-1];
    assign VALID_OUT = valid_q[DEPTH-1];
    assign OCCUPANCY = occ_q;

endmodule
